// File: rtl/reg_file_sb.sv
// reg_file_sb: 2**D x W register file with two forwarded combinational read
// ports, ALU / immediate / load-return write ports, and a busy scoreboard
// that raises a stall request on RAW/WAW hazards against outstanding loads.
module reg_file_sb #(
    parameter int W        = 8,
    parameter int D        = 4,
    parameter int RIM_ADDR = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [D-1:0] raddrA,
    input  logic [D-1:0] raddrB,
    input  logic         rdA_en,
    input  logic         rdB_en,
    output logic [W-1:0] data_outA,
    output logic [W-1:0] data_outB,
    input  logic         write_en,
    input  logic [D-1:0] waddr,
    input  logic [W-1:0] data_in,
    input  logic         write_imm,
    input  logic [W-1:0] imm_in,
    input  logic         ld_issue,
    input  logic [D-1:0] ld_iaddr,
    input  logic         ld_done,
    input  logic [D-1:0] ld_daddr,
    input  logic [W-1:0] ld_data,
    output logic         hazard,
    output logic [D:0]   busy_count,
    output logic         sb_err
);

    localparam int N = 1 << D;
    localparam logic [D-1:0] RIM = D'(RIM_ADDR);

    logic [W-1:0] regs [N];
    logic [N-1:0] busy;
    logic [N-1:0] busy_nxt;
    logic [D:0]   cnt_q;
    logic [D:0]   cnt_nxt;
    logic         sb_err_q;
    logic         wr_imm;
    logic         wr_ld;
    logic         wr_alu;
    logic         ld_set;

    // Qualified write strobes; register 0 is excluded from every port
    // (RIM is guaranteed nonzero, so the immediate port never hits it).
    assign wr_imm = write_en && write_imm;
    assign wr_ld  = ld_done && (ld_daddr != '0);
    assign wr_alu = write_en && (waddr != '0);
    assign ld_set = ld_issue && (ld_iaddr != '0);

    // Value seen at address a this cycle: winning write data (IMM > LD > ALU)
    // if a write targets a, otherwise the stored value.
    function automatic logic [W-1:0] fwd(
        input logic [D-1:0] a,
        input logic [W-1:0] stored,
        input logic         imm_v,
        input logic [W-1:0] imm_d,
        input logic         ld_v,
        input logic [D-1:0] ld_a,
        input logic [W-1:0] ld_d,
        input logic         alu_v,
        input logic [D-1:0] alu_a,
        input logic [W-1:0] alu_d
    );
        if (imm_v && a == RIM)       return imm_d;
        else if (ld_v && a == ld_a)  return ld_d;
        else if (alu_v && a == alu_a) return alu_d;
        else                          return stored;
    endfunction

    // A load returning this cycle releases its destination immediately.
    function automatic logic eff_busy(
        input logic [D-1:0] a,
        input logic [N-1:0] b,
        input logic         done,
        input logic [D-1:0] done_a
    );
        return b[a] && !(done && done_a == a);
    endfunction

    // Forwarded read ports; port A forces zero explicitly, port B relies on
    // register 0 never being written.
    assign data_outA = (raddrA == '0) ? '0 :
                       fwd(raddrA, regs[raddrA], wr_imm, imm_in, wr_ld, ld_daddr,
                           ld_data, wr_alu, waddr, data_in);
    assign data_outB = fwd(raddrB, regs[raddrB], wr_imm, imm_in, wr_ld, ld_daddr,
                           ld_data, wr_alu, waddr, data_in);

    // Stall request: reads, ALU destination and immediate destination
    // checked against the effective busy state.
    assign hazard = (rdA_en && eff_busy(raddrA, busy, ld_done, ld_daddr)) ||
                    (rdB_en && eff_busy(raddrB, busy, ld_done, ld_daddr)) ||
                    (write_en && eff_busy(waddr, busy, ld_done, ld_daddr)) ||
                    (wr_imm && eff_busy(RIM, busy, ld_done, ld_daddr));

    assign busy_count = cnt_q;
    assign sb_err     = sb_err_q;

    // Next busy vector: return clears, issue sets afterwards so set wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ld)  busy_nxt[ld_daddr] = 1'b0;
        if (ld_set) busy_nxt[ld_iaddr] = 1'b1;
        busy_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int i = 0; i < N; i++) begin
            cnt_nxt = cnt_nxt + (D+1)'(busy_nxt[i]);
        end
    end

    // Scoreboard state, registered population count and sticky error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy     <= '0;
            cnt_q    <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy  <= busy_nxt;
            cnt_q <= cnt_nxt;
            if (wr_ld && !busy[ld_daddr]) sb_err_q <= 1'b1;
        end
    end

    // Register array update with IMM > LD > ALU priority per entry.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < N; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < N; i++) begin
                if (wr_imm && RIM == D'(i))          regs[i] <= imm_in;
                else if (wr_ld && ld_daddr == D'(i)) regs[i] <= ld_data;
                else if (wr_alu && waddr == D'(i))   regs[i] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (W=8, D=4, RIM_ADDR=8).
module tb_reg_file_sb;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] raddrA, raddrB, waddr, ld_iaddr, ld_daddr;
    logic       rdA_en, rdB_en, write_en, write_imm, ld_issue, ld_done;
    logic [7:0] data_in, imm_in, ld_data;
    logic [7:0] data_outA, data_outB;
    logic       hazard, sb_err;
    logic [4:0] busy_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    reg_file_sb #(.W(8), .D(4), .RIM_ADDR(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .raddrA(raddrA), .raddrB(raddrB), .rdA_en(rdA_en), .rdB_en(rdB_en),
        .data_outA(data_outA), .data_outB(data_outB),
        .write_en(write_en), .waddr(waddr), .data_in(data_in),
        .write_imm(write_imm), .imm_in(imm_in),
        .ld_issue(ld_issue), .ld_iaddr(ld_iaddr),
        .ld_done(ld_done), .ld_daddr(ld_daddr), .ld_data(ld_data),
        .hazard(hazard), .busy_count(busy_count), .sb_err(sb_err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        raddrA = 0; raddrB = 0; rdA_en = 0; rdB_en = 0;
        write_en = 0; waddr = 0; data_in = 0; write_imm = 0; imm_in = 0;
        ld_issue = 0; ld_iaddr = 0; ld_done = 0; ld_daddr = 0; ld_data = 0;
    endtask

    task automatic test_reset();
        idle();
        RST_N = 0;
        #13;
        total_cnt++;
        if (data_outA !== 8'h00 || hazard !== 1'b0 || busy_count !== 5'd0 || sb_err !== 1'b0)
            $display("FAIL reset_state: outA=%h hazard=%b count=%0d sb_err=%b required 00/0/0/0",
                     data_outA, hazard, busy_count, sb_err);
        else pass_cnt++;
        RST_N = 1;
        tick();
        // mid-stream: R3=0x5A, load outstanding on R4
        write_en = 1; waddr = 3; data_in = 8'h5A; ld_issue = 1; ld_iaddr = 4;
        tick();
        idle();
        raddrB = 3; raddrA = 4; rdA_en = 1;
        #1;
        total_cnt++;
        if (data_outB !== 8'h5A || hazard !== 1'b1 || busy_count !== 5'd1)
            $display("FAIL pre_reset: outB=%h hazard=%b count=%0d required 5a/1/1",
                     data_outB, hazard, busy_count);
        else pass_cnt++;
        #1 RST_N = 0;
        #1;
        total_cnt++;
        if (data_outB !== 8'h00 || hazard !== 1'b0 || busy_count !== 5'd0)
            $display("FAIL mid_reset: outB=%h hazard=%b count=%0d required 00/0/0",
                     data_outB, hazard, busy_count);
        else pass_cnt++;
        #1 RST_N = 1;
        idle();
        tick();
    endtask

    task automatic test_forward();
        idle();
        write_en = 1; waddr = 8; data_in = 8'h11; write_imm = 1; imm_in = 8'h22; raddrA = 8;
        #1;
        total_cnt++;
        if (data_outA !== 8'h22) $display("FAIL fwd_imm_over_alu: outA=%h required 22", data_outA);
        else pass_cnt++;
        tick();
        idle(); raddrA = 8;
        #1;
        total_cnt++;
        if (data_outA !== 8'h22) $display("FAIL stored_imm: R8=%h required 22", data_outA);
        else pass_cnt++;
        // ALU and IMM to different addresses both commit
        write_en = 1; waddr = 7; data_in = 8'h44; write_imm = 1; imm_in = 8'h55; raddrB = 7;
        #1;
        total_cnt++;
        if (data_outB !== 8'h44) $display("FAIL fwd_alu: outB=%h required 44", data_outB);
        else pass_cnt++;
        tick();
        idle(); raddrA = 7; raddrB = 8;
        #1;
        total_cnt++;
        if (data_outA !== 8'h44 || data_outB !== 8'h55)
            $display("FAIL dual_commit: R7=%h R8=%h required 44/55", data_outA, data_outB);
        else pass_cnt++;
        // LD beats ALU to the same address (load outstanding, so no error)
        ld_issue = 1; ld_iaddr = 2;
        tick();
        idle();
        ld_done = 1; ld_daddr = 2; ld_data = 8'h66; write_en = 1; waddr = 2; data_in = 8'h99;
        raddrA = 2;
        #1;
        total_cnt++;
        if (data_outA !== 8'h66) $display("FAIL fwd_ld_over_alu: outA=%h required 66", data_outA);
        else pass_cnt++;
        tick();
        idle(); raddrB = 2;
        #1;
        total_cnt++;
        if (data_outB !== 8'h66 || busy_count !== 5'd0 || sb_err !== 1'b0)
            $display("FAIL stored_ld: R2=%h count=%0d sb_err=%b required 66/0/0",
                     data_outB, busy_count, sb_err);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        idle();
        write_en = 1; waddr = 0; data_in = 8'hFF; raddrA = 0; raddrB = 0;
        #1;
        total_cnt++;
        if (data_outA !== 8'h00 || data_outB !== 8'h00)
            $display("FAIL zero_fwd: outA=%h outB=%h required 00/00", data_outA, data_outB);
        else pass_cnt++;
        tick();
        idle();
        #1;
        total_cnt++;
        if (data_outA !== 8'h00 || data_outB !== 8'h00)
            $display("FAIL zero_stored: outA=%h outB=%h required 00/00", data_outA, data_outB);
        else pass_cnt++;
    endtask

    task automatic test_raw();
        idle();
        ld_issue = 1; ld_iaddr = 5;
        tick();
        idle(); rdA_en = 1; raddrA = 5;
        #1;
        total_cnt++;
        if (hazard !== 1'b1 || busy_count !== 5'd1)
            $display("FAIL raw_hazard: hazard=%b count=%0d required 1/1", hazard, busy_count);
        else pass_cnt++;
        rdA_en = 0;
        #1;
        total_cnt++;
        if (hazard !== 1'b0) $display("FAIL raw_unqualified: hazard=%b required 0", hazard);
        else pass_cnt++;
        rdA_en = 1; ld_done = 1; ld_daddr = 5; ld_data = 8'h77;
        #1;
        total_cnt++;
        if (hazard !== 1'b0 || data_outA !== 8'h77)
            $display("FAIL raw_release: hazard=%b outA=%h required 0/77", hazard, data_outA);
        else pass_cnt++;
        tick();
        idle(); raddrA = 5;
        #1;
        total_cnt++;
        if (busy_count !== 5'd0 || data_outA !== 8'h77)
            $display("FAIL raw_after: count=%0d R5=%h required 0/77", busy_count, data_outA);
        else pass_cnt++;
        // port B read hazard
        ld_issue = 1; ld_iaddr = 10;
        tick();
        idle(); rdB_en = 1; raddrB = 10;
        #1;
        total_cnt++;
        if (hazard !== 1'b1) $display("FAIL rawB_hazard: hazard=%b required 1", hazard);
        else pass_cnt++;
        idle(); ld_done = 1; ld_daddr = 10; ld_data = 8'h0A;
        tick();
        idle();
    endtask

    task automatic test_collide();
        idle();
        ld_issue = 1; ld_iaddr = 6;
        tick();
        idle();
        ld_done = 1; ld_daddr = 6; ld_data = 8'h33; ld_issue = 1; ld_iaddr = 6; raddrA = 6;
        #1;
        total_cnt++;
        if (data_outA !== 8'h33) $display("FAIL collide_fwd: outA=%h required 33", data_outA);
        else pass_cnt++;
        tick();
        idle(); raddrA = 6;
        #1;
        total_cnt++;
        if (data_outA !== 8'h33 || busy_count !== 5'd1 || sb_err !== 1'b0)
            $display("FAIL collide_state: R6=%h count=%0d sb_err=%b required 33/1/0",
                     data_outA, busy_count, sb_err);
        else pass_cnt++;
        write_en = 1; waddr = 6; data_in = 8'h44;
        #1;
        total_cnt++;
        if (hazard !== 1'b1) $display("FAIL waw_hazard: hazard=%b required 1", hazard);
        else pass_cnt++;
        tick();
        idle(); raddrA = 6;
        #1;
        total_cnt++;
        if (data_outA !== 8'h44) $display("FAIL write_under_hazard: R6=%h required 44", data_outA);
        else pass_cnt++;
        // immediate destination busy
        ld_issue = 1; ld_iaddr = 8;
        tick();
        idle(); write_en = 1; write_imm = 1; waddr = 1;
        #1;
        total_cnt++;
        if (hazard !== 1'b1 || busy_count !== 5'd2)
            $display("FAIL imm_hazard: hazard=%b count=%0d required 1/2", hazard, busy_count);
        else pass_cnt++;
        write_imm = 0;
        #1;
        total_cnt++;
        if (hazard !== 1'b0) $display("FAIL imm_hazard_off: hazard=%b required 0", hazard);
        else pass_cnt++;
        idle(); ld_done = 1; ld_daddr = 6; ld_data = 8'h01;
        tick();
        idle(); ld_done = 1; ld_daddr = 8; ld_data = 8'h02;
        tick();
        idle();
        #1;
        total_cnt++;
        if (busy_count !== 5'd0 || sb_err !== 1'b0)
            $display("FAIL collide_drain: count=%0d sb_err=%b required 0/0", busy_count, sb_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 1; i <= 3; i++) begin
            ld_issue = 1; ld_iaddr = 4'(i);
            tick();
            total_cnt++;
            if (busy_count !== 5'(i))
                $display("FAIL b2b_issue%0d: count=%0d required %0d", i, busy_count, i);
            else pass_cnt++;
        end
        // re-issue to busy register: no change, no error
        ld_iaddr = 2;
        tick();
        total_cnt++;
        if (busy_count !== 5'd3 || sb_err !== 1'b0)
            $display("FAIL b2b_reissue: count=%0d sb_err=%b required 3/0", busy_count, sb_err);
        else pass_cnt++;
        idle();
        for (int i = 1; i <= 3; i++) begin
            ld_done = 1; ld_daddr = 4'(i); ld_data = 8'(8'hA0 + i);
            tick();
            total_cnt++;
            if (busy_count !== 5'(3 - i))
                $display("FAIL b2b_done%0d: count=%0d required %0d", i, busy_count, 3 - i);
            else pass_cnt++;
        end
        idle();
    endtask

    task automatic test_spurious();
        idle();
        ld_done = 1; ld_daddr = 9; ld_data = 8'h3C;
        #1;
        total_cnt++;
        if (sb_err !== 1'b0) $display("FAIL spur_before: sb_err=%b required 0", sb_err);
        else pass_cnt++;
        tick();
        idle(); raddrB = 9;
        #1;
        total_cnt++;
        if (data_outB !== 8'h3C || sb_err !== 1'b1)
            $display("FAIL spur_write: R9=%h sb_err=%b required 3c/1", data_outB, sb_err);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            tick();
            total_cnt++;
            if (sb_err !== 1'b1) $display("FAIL spur_hold%0d: sb_err=%b required 1", i, sb_err);
            else pass_cnt++;
        end
        #1 RST_N = 0;
        #1;
        total_cnt++;
        if (sb_err !== 1'b0) $display("FAIL spur_reset: sb_err=%b required 0", sb_err);
        else pass_cnt++;
        #1 RST_N = 1;
        // busy bit lost across reset makes the late return spurious
        ld_issue = 1; ld_iaddr = 11;
        tick();
        idle();
        #1 RST_N = 0;
        #1 RST_N = 1;
        ld_done = 1; ld_daddr = 11; ld_data = 8'h5;
        tick();
        idle();
        total_cnt++;
        if (sb_err !== 1'b1 || busy_count !== 5'd0)
            $display("FAIL post_reset_return: sb_err=%b count=%0d required 1/0", sb_err, busy_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_zero();
        test_raw();
        test_collide();
        test_back_to_back();
        test_spurious();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 8-entry datapath register file.
- Provides 2**D entries of W bits, two combinational read ports, and an ALU write port.
- Adds a dedicated load-return write port, a dedicated immediate register (RIM), same-cycle write-to-read forwarding, and a per-register busy scoreboard that flags RAW/WAW hazards against outstanding loads.
- Sits between decode (read/hazard) and writeback/memory return (writes).

Parameters:
- W, 8, data path width in bits
- D, 4, address width; 2**D registers
- RIM_ADDR, 8, index of the special-purpose immediate register; must be nonzero and below 2**D

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous active-low reset
- raddrA  in  D  read address A; address 0 always reads 0
- raddrB  in  D  read address B
- rdA_en  in  1  decode uses port A (hazard qualify)
- rdB_en  in  1  decode uses port B (hazard qualify)
- data_outA  out  W  read data A (forwarded)
- data_outB  out  W  read data B (forwarded)
- write_en  in  1  ALU write strobe
- waddr  in  D  ALU write address
- data_in  in  W  ALU write data
- write_imm  in  1  with write_en, load imm_in into RIM_ADDR
- imm_in  in  W  immediate data
- ld_issue  in  1  load issued; mark ld_iaddr busy
- ld_iaddr  in  D  destination of issued load
- ld_done  in  1  load data returning
- ld_daddr  in  D  destination of returning load
- ld_data  in  W  returning load data
- hazard  out  1  stall request to decode
- busy_count  out  D+1  number of busy registers
- sb_err  out  1  sticky: ld_done to a non-busy register

Behaviour:
- Reset (RST_N low, asynchronous): all registers 0, all busy bits 0, sb_err 0. Consequently data_outA/B=0, hazard=0, busy_count=0.
- Register 0 is never written by any port and always holds 0.
- Writes on posedge CLK. Sources and conditions:
  - ALU: write_en && waddr!=0 writes data_in.
  - IMM: write_en && write_imm writes imm_in to RIM_ADDR.
  - LD: ld_done && ld_daddr!=0 writes ld_data.
- Same-address write collision priority: IMM > LD > ALU. ALU and IMM to different addresses both commit in the same cycle.
- Reads are combinational with forwarding. If a read address matches an address being written this cycle, the output is the winning write data (same priority); otherwise it is the stored value. raddrA==0 forces data_outA=0. raddrB==0 yields 0 because register 0 is always 0.
- Scoreboard (busy[i], i=1..2**D-1; busy[0] is constantly 0):
  - ld_done && ld_daddr!=0: clears busy[ld_daddr] next cycle.
  - ld_issue && ld_iaddr!=0: sets busy[ld_iaddr] next cycle.
  - Same address issued and done in the same cycle: set wins (new load outstanding), and the returning data is still written.
  - ld_issue to an already-busy register: busy stays 1; no error.
  - ld_done && ld_daddr!=0 && !busy[ld_daddr]: data is written, sb_err set to 1 and held until reset.
- hazard is combinational and asserts if any of the following hold:
  - rdA_en && eff_busy(raddrA)
  - rdB_en && eff_busy(raddrB)
  - write_en && eff_busy(waddr) (WAW)
  - write_en && write_imm && eff_busy(RIM_ADDR)
  - where eff_busy(a) = busy[a] && !(ld_done && ld_daddr==a), i.e. a returning load releases its hazard in the return cycle.
  - hazard only reports; the block never suppresses a write that occurs while hazard is high.
- busy_count is the registered population count of busy bits, updated in the same cycle as the busy bits. Maximum value is 2**D-1.
- Reset mid-operation: all outstanding busy bits are discarded. Subsequent ld_done returns set sb_err.

Test Plan:
- Reset mid-stream: write R3=0x5A, then pulse RST_N low between edges -> data_outB(raddrB=3)=0x00 immediately; hazard=0; busy_count=0.
- Forwarding and priority: same cycle, write_en with waddr=8, data_in=0x11, write_imm=1, imm_in=0x22, raddrA=8 -> data_outA=0x22 combinationally; R8=0x22 after the edge.
- Zero register: write_en with waddr=0, data_in=0xFF -> data_outA(raddrA=0)=0x00 and data_outB(raddrB=0)=0x00.
- Scoreboard RAW: ld_issue with ld_iaddr=5; next cycle rdA_en=1, raddrA=5 -> hazard=1, busy_count=1. Then ld_done with ld_daddr=5, ld_data=0x77 -> same cycle hazard=0, data_outA=0x77; next cycle busy_count=0.
- Issue and done collide: R6 busy; ld_done with ld_daddr=6, ld_data=0x33 and ld_issue with ld_iaddr=6 in the same cycle -> R6=0x33, busy[6] remains 1, busy_count unchanged; WAW check with write_en, waddr=6 -> hazard=1.
- Spurious return: ld_done with ld_daddr=9 while R9 is not busy -> R9 written, sb_err=1 and held across 10 further cycles until RST_N low.
